// File: rtl/rot_align_detect.sv
// rtl/rot_align_detect.sv - rotate-and-compare word alignment search
//
// Loads a word and a target pattern on an accepted start, then rotates the
// word one position per clock (right or left, chosen at start) until it equals
// the pattern or every distinct rotation has been tried.
//
// Ports:
//   clk        rising-edge clock
//   async_rst  asynchronous active-high reset
//   start      request pulse, only honoured in IDLE
//   dir        rotate direction captured at start (0 = right, 1 = left)
//   data_in    word to align, captured at start
//   pattern    target word, captured at start
//   q          working / aligned word
//   busy       high while searching
//   done       one-cycle completion strobe
//   found      match result, held until the next accepted start
//   rot_cnt    rotations applied to reach the match (0 when not found)
//
// DW must be >= 2 and 2**CW must be >= DW.

module rot_align_detect #(
   parameter int DW = 4,
   parameter int CW = 2
) (
   input  logic          clk,
   input  logic          async_rst,
   input  logic          start,
   input  logic          dir,
   input  logic [DW-1:0] data_in,
   input  logic [DW-1:0] pattern,
   output logic [DW-1:0] q,
   output logic          busy,
   output logic          done,
   output logic          found,
   output logic [CW-1:0] rot_cnt
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SEARCH,
      S_DONE
   } state_t;

   state_t        state_q, state_d;
   logic [DW-1:0] q_q, q_d;
   logic [DW-1:0] pat_q, pat_d;
   logic          dir_q, dir_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          found_q, found_d;
   logic [CW-1:0] rot_q, rot_d;

   // Last rotation index; reaching it without a match ends the search.
   localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);

   always_comb begin
      state_d = state_q;
      q_d     = q_q;
      pat_d   = pat_q;
      dir_d   = dir_q;
      cnt_d   = cnt_q;
      found_d = found_q;
      rot_d   = rot_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_SEARCH;
               q_d     = data_in;
               pat_d   = pattern;
               dir_d   = dir;
               cnt_d   = '0;
            end
         end
         S_SEARCH: begin
            // Compare before rotating so the smallest matching rotation wins.
            if (q_q == pat_q) begin
               found_d = 1'b1;
               rot_d   = cnt_q;
               state_d = S_DONE;
            end else if (cnt_q == CNT_LAST) begin
               found_d = 1'b0;
               rot_d   = '0;
               state_d = S_DONE;
            end else begin
               // left: q[i] <= q[i-1]; right: q[i] <= q[i+1]
               q_d   = dir_q ? {q_q[DW-2:0], q_q[DW-1]} : {q_q[0], q_q[DW-1:1]};
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge async_rst) begin
      if (async_rst) begin
         state_q <= S_IDLE;
         q_q     <= '0;
         pat_q   <= '0;
         dir_q   <= 1'b0;
         cnt_q   <= '0;
         found_q <= 1'b0;
         rot_q   <= '0;
      end else begin
         state_q <= state_d;
         q_q     <= q_d;
         pat_q   <= pat_d;
         dir_q   <= dir_d;
         cnt_q   <= cnt_d;
         found_q <= found_d;
         rot_q   <= rot_d;
      end
   end

   assign q       = q_q;
   assign busy    = (state_q == S_SEARCH);
   assign done    = (state_q == S_DONE);
   assign found   = found_q;
   assign rot_cnt = rot_q;

endmodule

// File: tb/tb_rot_align_detect.sv
// tb/tb_rot_align_detect.sv - self-checking bench for rot_align_detect

module tb_rot_align_detect;

   logic       clk = 1'b0;
   logic       async_rst = 1'b1;
   logic       start = 1'b0;
   logic       dir = 1'b0;
   logic [3:0] data_in = '0;
   logic [3:0] pattern = '0;
   logic [3:0] q;
   logic       busy;
   logic       done;
   logic       found;
   logic [1:0] rot_cnt;

   int n_checks = 0;
   int n_err = 0;

   typedef struct {
      logic       f;
      logic [1:0] r;
      logic [3:0] w;
      int         lat;
   } exp_t;

   exp_t sb[$];

   rot_align_detect #(.DW(4), .CW(2)) dut (
      .clk      (clk),
      .async_rst(async_rst),
      .start    (start),
      .dir      (dir),
      .data_in  (data_in),
      .pattern  (pattern),
      .q        (q),
      .busy     (busy),
      .done     (done),
      .found    (found),
      .rot_cnt  (rot_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called at the negedge following the accept edge; counts edges until done.
   task automatic wait_done(output int n, output int bc, input bit scramble);
      n = 0;
      bc = 0;
      while (done !== 1'b1 && n < 12) begin
         if (busy === 1'b1) bc++;
         @(negedge clk);
         n++;
         if (scramble) begin
            data_in = 4'($urandom);
            pattern = 4'($urandom);
            dir     = 1'($urandom);
         end
      end
   endtask

   task automatic check_pop(input string tag, input int n, input int bc);
      exp_t e;
      if (sb.size() == 0) begin
         chk({tag, "_sb_empty"}, 1, 0);
         return;
      end
      e = sb.pop_front();
      chk({tag, "_done_seen"}, done, 1'b1);
      chk({tag, "_latency"}, n, e.lat);
      chk({tag, "_busy_cycles"}, bc, e.lat);
      chk({tag, "_found"}, found, e.f);
      chk({tag, "_rot_cnt"}, rot_cnt, e.r);
      chk({tag, "_q"}, q, e.w);
   endtask

   task automatic run(input string tag, input logic [3:0] din, input logic [3:0] pat,
                      input logic d, input logic ef, input logic [1:0] er,
                      input logic [3:0] eq, input int lat);
      int n, bc;
      sb.push_back('{ef, er, eq, lat});
      @(negedge clk);
      start = 1'b1; data_in = din; pattern = pat; dir = d;
      chk({tag, "_busy_accept_cycle"}, busy, 1'b0);
      @(negedge clk);
      // Inputs changed after accept must not disturb the search.
      start = 1'b0; data_in = ~din; pattern = ~pat; dir = ~d;
      wait_done(n, bc, 1'b0);
      check_pop(tag, n, bc);
      @(negedge clk);
      chk({tag, "_done_pulse_1cyc"}, done, 1'b0);
      chk({tag, "_idle_busy"}, busy, 1'b0);
      chk({tag, "_hold_found"}, found, ef);
      chk({tag, "_hold_rot"}, rot_cnt, er);
      chk({tag, "_hold_q"}, q, eq);
   endtask

   initial begin
      int n, bc;
      #12;
      chk("rst_q", q, 4'h0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_found", found, 1'b0);
      chk("rst_rot", rot_cnt, 2'd0);
      @(negedge clk);
      async_rst = 1'b0;

      run("r_0001_1000", 4'b0001, 4'b1000, 1'b0, 1'b1, 2'd1, 4'b1000, 2);
      run("l_0001_1000", 4'b0001, 4'b1000, 1'b1, 1'b1, 2'd3, 4'b1000, 4);
      run("l_nomatch",   4'b0011, 4'b0111, 1'b1, 1'b0, 2'd0, 4'b1001, 4);
      run("r_1010_same", 4'b1010, 4'b1010, 1'b0, 1'b1, 2'd0, 4'b1010, 1);
      run("l_1010_same", 4'b1010, 4'b1010, 1'b1, 1'b1, 2'd0, 4'b1010, 1);
      run("r_periodic",  4'b0101, 4'b1010, 1'b0, 1'b1, 2'd1, 4'b1010, 2);
      run("r_nomatch",   4'b0001, 4'b0011, 1'b0, 1'b0, 2'd0, 4'b0010, 4);

      // Idle with no start: outputs hold while inputs wander.
      @(negedge clk);
      data_in = 4'b1111; pattern = 4'b0000;
      @(negedge clk);
      chk("idle_hold_q", q, 4'b0010);
      chk("idle_hold_busy", busy, 1'b0);

      // start held high across a search with changing inputs.
      sb.push_back('{1'b1, 2'd3, 4'b1000, 4});
      start = 1'b1; data_in = 4'b0001; pattern = 4'b1000; dir = 1'b1;
      @(negedge clk);
      wait_done(n, bc, 1'b1);
      check_pop("hold_start_first", n, bc);
      data_in = 4'b1100; pattern = 4'b0110; dir = 1'b0;
      @(negedge clk);
      chk("hold_start_idle_busy", busy, 1'b0);
      chk("hold_start_idle_done", done, 1'b0);
      sb.push_back('{1'b1, 2'd1, 4'b0110, 2});
      @(negedge clk);
      start = 1'b0;
      wait_done(n, bc, 1'b0);
      check_pop("hold_start_second", n, bc);

      // Reset in the middle of a search, between clock edges.
      @(negedge clk);
      start = 1'b1; data_in = 4'b0001; pattern = 4'b1000; dir = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      #2 async_rst = 1'b1;
      #1;
      chk("midrst_q", q, 4'h0);
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_done", done, 1'b0);
      chk("midrst_found", found, 1'b0);
      chk("midrst_rot", rot_cnt, 2'd0);
      @(posedge clk);
      #1;
      chk("inrst_done", done, 1'b0);
      chk("inrst_busy", busy, 1'b0);
      @(negedge clk);
      start = 1'b1; data_in = 4'b0011; pattern = 4'b0110; dir = 1'b1;
      #2 async_rst = 1'b0;
      sb.push_back('{1'b1, 2'd1, 4'b0110, 2});
      @(negedge clk);
      start = 1'b0;
      chk("postrst_accept_busy", busy, 1'b1);
      wait_done(n, bc, 1'b0);
      check_pop("postrst", n, bc);

      chk("sb_drained", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
